// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Drives the 4:1 mux data inputs with a captured word, steps the select through
// 0..3 with a programmable dwell per value, and samples the mux output back into
// rx_word so the mux can be exercised in-system.
//
// Optional feature: define MUX_SEQ_CHECK_EN to add the rx_word / mux_in compare
// that drives `mismatch`. Without it `mismatch` is tied low.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs hold the result of the last scan
// SCAN   | stepping sel 0..3, sampling mux_out at the end of each dwell
// DONE   | one-cycle completion pulse, busy still high

module mux_sel_sequencer #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] data_in,
   output logic [3:0] mux_in,
   output logic [1:0] sel,
   input  logic       mux_out,
   output logic [3:0] rx_word,
   output logic       busy,
   output logic       done,
   output logic       mismatch
);

   // A dwell of 0 would never reach its terminal count, so it runs as 1.
   localparam int         DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
   localparam logic [7:0] CNT_LAST  = 8'(DWELL_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] mux_in_q, mux_in_d;
   logic [3:0] rx_q, rx_d;
   logic [7:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
`ifdef MUX_SEQ_CHECK_EN
   logic       mismatch_q, mismatch_d;
`endif

   // Next-state and next-output computation for the scan sequence.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      mux_in_d = mux_in_q;
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef MUX_SEQ_CHECK_EN
      mismatch_d = mismatch_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_SCAN;
               mux_in_d = data_in;
               rx_d     = 4'b0000;
               sel_d    = 2'd0;
               cnt_d    = 8'd0;
               busy_d   = 1'b1;
`ifdef MUX_SEQ_CHECK_EN
               mismatch_d = 1'b0;
`endif
            end
         end
         ST_SCAN: begin
            if (cnt_q == CNT_LAST) begin
               rx_d[sel_q] = mux_out;
               cnt_d       = 8'd0;
               if (sel_q == 2'd3) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
`ifdef MUX_SEQ_CHECK_EN
                  // Compare against rx_d so the bit sampled this cycle is included.
                  mismatch_d = (rx_d != mux_in_q);
`endif
               end else begin
                  sel_d = sel_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Register state and all outputs; synchronous reset abandons any scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sel_q    <= 2'd0;
         mux_in_q <= 4'b0000;
         rx_q     <= 4'b0000;
         cnt_q    <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MUX_SEQ_CHECK_EN
         mismatch_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         mux_in_q <= mux_in_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MUX_SEQ_CHECK_EN
         mismatch_q <= mismatch_d;
`endif
      end
   end

   assign sel     = sel_q;
   assign mux_in  = mux_in_q;
   assign rx_word = rx_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef MUX_SEQ_CHECK_EN
   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

endmodule
